// File: rtl/multiplier_pkg.sv
// rtl/multiplier_pkg.sv - shared widths and operand/product types for the array multiplier
package multiplier_pkg;

  localparam int WIDTH      = 4;
  localparam int PROD_WIDTH = 2 * WIDTH;

  typedef logic [WIDTH-1:0]      operand_t;
  typedef logic [PROD_WIDTH-1:0] product_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell used by the multiplier array
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign sum      = half_sum ^ cin;
  assign cout     = (a & b) | (cin & half_sum);

endmodule

// File: rtl/multiplier_4x4.sv
// rtl/multiplier_4x4.sv - unsigned AND/full-adder array multiplier, registered product
// MULTIPLIER_PIPE_EN registers the operands ahead of the array (latency 2 instead of 1).
module multiplier_4x4 #(
  parameter int WIDTH = multiplier_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               in_valid,
  output logic [2*WIDTH-1:0] p,
  output logic               out_valid
);

  import multiplier_pkg::*;

  localparam int CW = WIDTH + 1;

  logic [WIDTH-1:0]         arr_a;
  logic [WIDTH-1:0]         arr_b;
  logic                     arr_v;
  logic [WIDTH*WIDTH-1:0]   pp;
  logic [WIDTH*WIDTH-1:0]   sums;
  logic [(WIDTH-1)*CW-1:0]  chain;
  logic [WIDTH-1:0]         row_cout;
  logic [2*WIDTH-1:0]       prod;

`ifdef MULTIPLIER_PIPE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arr_a <= '0;
      arr_b <= '0;
      arr_v <= 1'b0;
    end else begin
      arr_a <= a;
      arr_b <= b;
      arr_v <= in_valid;
    end
  end
`else
  assign arr_a = a;
  assign arr_b = b;
  assign arr_v = in_valid;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_pp_row
    for (genvar j = 0; j < WIDTH; j++) begin : g_pp_col
      assign pp[i*WIDTH+j] = arr_a[j] & arr_b[i];
    end
  end

  assign sums[WIDTH-1:0] = pp[WIDTH-1:0];
  assign row_cout[0]     = 1'b0;

  // Each row adds the next partial product to the previous row's sum shifted down one bit.
  for (genvar i = 1; i < WIDTH; i++) begin : g_row
    assign chain[(i-1)*CW] = 1'b0;
    for (genvar j = 0; j < WIDTH; j++) begin : g_col
      logic x_bit;
      if (j < WIDTH - 1) begin : g_inner
        assign x_bit = sums[(i-1)*WIDTH+j+1];
      end else begin : g_top
        assign x_bit = row_cout[i-1];
      end
      full_adder u_fa (
        .a    (x_bit),
        .b    (pp[i*WIDTH+j]),
        .cin  (chain[(i-1)*CW+j]),
        .sum  (sums[i*WIDTH+j]),
        .cout (chain[(i-1)*CW+j+1])
      );
    end
    assign row_cout[i] = chain[(i-1)*CW+WIDTH];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_prod_lo
    assign prod[i] = sums[i*WIDTH];
  end
  assign prod[2*WIDTH-1:WIDTH] = {row_cout[WIDTH-1], sums[WIDTH*WIDTH-1 -: WIDTH-1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= arr_v;
      if (arr_v) begin
        p <= prod;
      end
    end
  end

endmodule

// File: tb/tb_multiplier_4x4.sv
// tb/tb_multiplier_4x4.sv - directed self-checking bench for multiplier_4x4
module tb_multiplier_4x4;

  import multiplier_pkg::*;

`ifdef MULTIPLIER_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic     clk = 1'b0;
  logic     rst_n;
  operand_t a;
  operand_t b;
  logic     in_valid;
  product_t p;
  logic     out_valid;

  int checks   = 0;
  int failures = 0;

  product_t stage_p [LAT];
  logic     stage_v [LAT];
  product_t exp_p;
  logic     exp_v;

  always #5 clk = ~clk;

  multiplier_4x4 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .p         (p),
    .out_valid (out_valid)
  );

  task automatic check_out(input string tag);
    checks++;
    assert (p === exp_p) else begin
      failures++;
      $error("FAIL %s p observed=%0d expected=%0d", tag, p, exp_p);
    end
    checks++;
    assert (out_valid === exp_v) else begin
      failures++;
      $error("FAIL %s out_valid observed=%0b expected=%0b", tag, out_valid, exp_v);
    end
  endtask

  // prod is the hand-computed product for this operand pair; the stage array only delays it.
  task automatic drive(input string tag, input logic rst, input logic v,
                       input int av, input int bv, input int prod);
    rst_n    = rst;
    in_valid = v;
    a        = operand_t'(av);
    b        = operand_t'(bv);
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < LAT; i++) begin
        stage_p[i] = '0;
        stage_v[i] = 1'b0;
      end
      exp_p = '0;
      exp_v = 1'b0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        stage_p[i] = stage_p[i-1];
        stage_v[i] = stage_v[i-1];
      end
      stage_p[0] = product_t'(prod);
      stage_v[0] = v;
      exp_v = stage_v[LAT-1];
      if (exp_v) exp_p = stage_p[LAT-1];
    end
    #1;
    check_out(tag);
  endtask

  initial begin
    drive("reset0", 1'b0, 1'b0, 0, 0, 0);
    drive("reset_ignores_valid", 1'b0, 1'b1, 15, 15, 225);

    drive("zero_zero", 1'b1, 1'b1, 0, 0, 0);
    for (int k = 0; k < 7; k++) drive("max_held", 1'b1, 1'b1, 15, 15, 225);

    drive("b2b_7x9",   1'b1, 1'b1, 7, 9, 63);
    drive("b2b_10x12", 1'b1, 1'b1, 10, 12, 120);
    drive("b2b_1x13",  1'b1, 1'b1, 1, 13, 13);
    drive("b2b_15x0",  1'b1, 1'b1, 15, 0, 0);
    drive("one_x_15",  1'b1, 1'b1, 1, 15, 15);
    drive("zero_x_11", 1'b1, 1'b1, 0, 11, 0);
    drive("b2b_6x5",   1'b1, 1'b1, 6, 5, 30);

    drive("hold_a", 1'b1, 1'b0, 3, 5, 0);
    drive("hold_b", 1'b1, 1'b0, 9, 14, 0);
    drive("hold_c", 1'b1, 1'b0, 15, 15, 0);
    drive("hold_d", 1'b1, 1'b0, 2, 8, 0);

    drive("accept_max", 1'b1, 1'b1, 15, 15, 225);
    drive("reset_mid",  1'b0, 1'b0, 0, 0, 0);
    for (int k = 0; k < 3; k++) drive("post_reset", 1'b1, 1'b0, 4, 4, 0);

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        drive($sformatf("exh_%0dx%0d", i, j), 1'b1, 1'b1, i, j, i * j);
      end
    end
    for (int k = 0; k < LAT + 1; k++) drive("flush", 1'b1, 1'b0, k, 15 - k, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multiplier_4x4.md
MULTIPLIER_4X4 -- requirements
Module: multiplier_4x4

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; product width is 2*WIDTH.
REQ-002 Clocking and reset SHALL be one clock with a synchronous, active-low reset: clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 a  input  WIDTH  unsigned multiplicand.
REQ-006 b  input  WIDTH  unsigned multiplier.
REQ-007 in_valid  input  1  qualifies a/b in the current cycle.
REQ-008 p  output  2*WIDTH  registered unsigned product.
REQ-009 out_valid  output  1  high for exactly one cycle per accepted operand pair, aligned with p.

Function
REQ-010 p SHALL equal a*b unsigned, full 2*WIDTH-bit result, no truncation or saturation; 15*15 = 225 at WIDTH=4.
REQ-011 Default latency SHALL be 1 cycle: operands sampled with in_valid=1 at edge N appear on p with out_valid=1 after edge N+1.
REQ-012 Module SHALL accept a new operand pair every cycle, with no stall and no backpressure.
REQ-013 When in_valid=0, p SHALL hold its last value and out_valid SHALL be 0 after the next edge.
REQ-014 Product SHALL be formed as an AND-gate partial-product array reduced by rows of full adders (carry-save or ripple), not with a behavioural multiply operator.
REQ-015 Boundary: any operand of 0 SHALL give p=0; a=1 SHALL give p=b; all-ones operands SHALL give p=(2^WIDTH-1)^2.
REQ-016 Repeated identical operands on consecutive cycles SHALL give identical p with out_valid asserted each cycle.

Reset
REQ-017 While rst_n=0 at a rising edge, p SHALL become 0, out_valid SHALL become 0, and every pipeline register SHALL clear.
REQ-018 Reset asserted mid-operation SHALL discard all in-flight results; no out_valid SHALL follow for operands accepted before reset.
REQ-019 in_valid SHALL be ignored during any cycle in which rst_n=0.

Configuration
REQ-020 Macro MULTIPLIER_PIPE_EN: when defined, a and b SHALL be registered before the array, giving latency 2 cycles with full throughput maintained and a valid bit carried alongside.
REQ-021 When MULTIPLIER_PIPE_EN is undefined, latency SHALL be 1 cycle per REQ-011.
REQ-022 Both configurations SHALL produce bit-identical p sequences apart from the latency offset.

Structure
REQ-023 Shared package multiplier_pkg SHALL hold the WIDTH default, PROD_WIDTH = 2*WIDTH, and the operand/product typedefs.
REQ-024 One sub-module, full_adder (inputs a, b, cin; outputs sum, cout), SHALL be instantiated for each array cell.
REQ-025 The array SHALL be built with generate loops over WIDTH, so WIDTH=8 elaborates without edits.

Verification
REQ-026 Reset, then a=0, b=0 with in_valid=1: after 1 cycle, p=0 and out_valid=1.
REQ-027 a=15, b=15 held 7 consecutive cycles: p=225 with out_valid=1 every cycle after the latency.
REQ-028 Back-to-back pairs (7,9), (10,12), (1,13), (15,0): p=63, 120, 13, 0 on consecutive cycles.
REQ-029 rst_n driven low one cycle after (15,15) is accepted: p=0, out_valid=0, and no 225 appears.
REQ-030 Exhaustive 256 pairs at WIDTH=4 against a reference model, in both MULTIPLIER_PIPE_EN settings: zero mismatches, latency 1 and 2 respectively.
REQ-031 in_valid=0 with changing a/b: p holds its last value and out_valid=0.
